// File: rtl/axis_zero_sequencer.sv
// Blanking/acquisition sequencer for an AXI-stream zeroer: holds data at zero for a
// programmable number of cycles after a trigger, then opens for a fixed number of beats.
module axis_zero_sequencer #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNTR_WIDTH       = 32
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  trigger,
  input  logic [CNTR_WIDTH-1:0] cfg_blank,
  input  logic [CNTR_WIDTH-1:0] cfg_window,
  input  logic                  mon_tvalid,
  input  logic                  mon_tready,
  output logic                  zero,
  output logic                  busy,
  output logic                  done,
  output logic [CNTR_WIDTH-1:0] sts_count
);

  typedef enum logic [1:0] {IDLE, BLANK, ACQ, DONE} state_t;

  localparam logic [CNTR_WIDTH-1:0] ONE  = {{(CNTR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNTR_WIDTH-1:0] ZERO = '0;
  // Stream width only matters to the zeroer; here it just qualifies the beat (folds to 1).
  localparam logic STREAM_EN = (AXIS_TDATA_WIDTH > 0);

  state_t                state, state_d;
  logic                  trigger_q;
  logic                  armed;
  logic [CNTR_WIDTH-1:0] blank_l, window_l, cyc_cnt;
  logic                  zero_d, busy_d, done_d;
  logic                  trigger_edge, beat;

  // armed stays low after reset until trigger is seen low, so a trigger held
  // through reset release cannot masquerade as a fresh rising edge.
  assign trigger_edge = trigger & ~trigger_q & armed;
  assign beat         = mon_tvalid & mon_tready & STREAM_EN;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state     <= IDLE;
      trigger_q <= 1'b0;
      armed     <= 1'b0;
      blank_l   <= ZERO;
      window_l  <= ZERO;
      cyc_cnt   <= ZERO;
      sts_count <= ZERO;
      zero      <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      trigger_q <= trigger;
      armed     <= armed | ~trigger;
      zero      <= zero_d;
      busy      <= busy_d;
      done      <= done_d;
      case (state)
        IDLE: if (trigger_edge) begin
          blank_l   <= cfg_blank;
          window_l  <= cfg_window;
          sts_count <= ZERO;
          cyc_cnt   <= ZERO;
        end
        BLANK: cyc_cnt <= cyc_cnt + ONE;
        ACQ:   if (beat) sts_count <= sts_count + ONE;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (trigger_edge) begin
        if (cfg_blank != ZERO)       state_d = BLANK;
        else if (cfg_window != ZERO) state_d = ACQ;
        else                         state_d = DONE;
      end
      BLANK: if (cyc_cnt == blank_l - ONE)
        state_d = (window_l != ZERO) ? ACQ : DONE;
      ACQ:  if (beat && (sts_count + ONE == window_l)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, keeping them glitch-free.
  always_comb begin
    zero_d = (state_d != ACQ);
    busy_d = (state_d == BLANK) || (state_d == ACQ);
    done_d = (state_d == DONE);
  end

endmodule

// File: tb/tb_axis_zero_sequencer.sv
// Directed bench for axis_zero_sequencer: per-cycle expected outputs are queued
// ahead of each sequence and popped/compared after every clock edge.
module tb_axis_zero_sequencer;
  localparam int W = 32;

  logic         aclk = 1'b0;
  logic         areset, trigger, mon_tvalid, mon_tready;
  logic [W-1:0] cfg_blank, cfg_window;
  logic         zero, busy, done;
  logic [W-1:0] sts_count;

  typedef struct {
    string        tag;
    logic         z, b, d;
    logic [W-1:0] c;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  axis_zero_sequencer #(.AXIS_TDATA_WIDTH(32), .CNTR_WIDTH(W)) dut (
    .aclk(aclk), .areset(areset), .trigger(trigger),
    .cfg_blank(cfg_blank), .cfg_window(cfg_window),
    .mon_tvalid(mon_tvalid), .mon_tready(mon_tready),
    .zero(zero), .busy(busy), .done(done), .sts_count(sts_count)
  );

  always #5 aclk = ~aclk;

  task automatic push(input string tag, input logic z, input logic b, input logic d,
                      input logic [W-1:0] c);
    exp_t e;
    e.tag = tag; e.z = z; e.b = b; e.d = d; e.c = c;
    q.push_back(e);
  endtask

  task automatic run(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge aclk);
      #1;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL scoreboard_underflow no expected entry at t=%0t", $time);
      end else begin
        e = q.pop_front();
        checks++;
        assert (zero === e.z) else begin
          errors++; $error("FAIL %s zero obs=%0b exp=%0b", e.tag, zero, e.z);
        end
        checks++;
        assert (busy === e.b) else begin
          errors++; $error("FAIL %s busy obs=%0b exp=%0b", e.tag, busy, e.b);
        end
        checks++;
        assert (done === e.d) else begin
          errors++; $error("FAIL %s done obs=%0b exp=%0b", e.tag, done, e.d);
        end
        checks++;
        assert (sts_count === e.c) else begin
          errors++; $error("FAIL %s sts_count obs=%0d exp=%0d", e.tag, sts_count, e.c);
        end
      end
    end
  endtask

  initial begin
    areset = 1'b1; trigger = 1'b0; mon_tvalid = 1'b0; mon_tready = 1'b0;
    cfg_blank = '0; cfg_window = '0;
    push("reset", 1, 0, 0, 0); push("reset", 1, 0, 0, 0);
    run(2);
    areset = 1'b0;
    push("idle", 1, 0, 0, 0);
    run(1);

    // blank=4, window=3, continuous beats
    cfg_blank = 4; cfg_window = 3; mon_tvalid = 1; mon_tready = 1; trigger = 1;
    repeat (4) push("b4w3_blank", 1, 1, 0, 0);
    push("b4w3_acq", 0, 1, 0, 0); push("b4w3_acq", 0, 1, 0, 1); push("b4w3_acq", 0, 1, 0, 2);
    push("b4w3_done", 1, 0, 1, 3); push("b4w3_idle", 1, 0, 0, 3);
    run(9);
    trigger = 0;
    push("b4w3_hold", 1, 0, 0, 3);
    run(1);

    // blank=2, window=2, a beat only every third cycle
    cfg_blank = 2; cfg_window = 2; mon_tready = 1;
    push("sparse_blank", 1, 1, 0, 0); push("sparse_blank", 1, 1, 0, 0);
    push("sparse_acq", 0, 1, 0, 0); push("sparse_acq", 0, 1, 0, 0); push("sparse_acq", 0, 1, 0, 0);
    push("sparse_acq", 0, 1, 0, 1); push("sparse_acq", 0, 1, 0, 1); push("sparse_acq", 0, 1, 0, 1);
    push("sparse_done", 1, 0, 1, 2); push("sparse_idle", 1, 0, 0, 2);
    for (int k = 1; k <= 10; k++) begin
      trigger    = (k <= 2);
      mon_tvalid = (k == 6) || (k == 9);
      run(1);
    end

    // blank=0, window=0: immediate done, never busy
    cfg_blank = 0; cfg_window = 0; mon_tvalid = 1; trigger = 1;
    push("zero_cfg_done", 1, 0, 1, 0); push("zero_cfg_idle", 1, 0, 0, 0);
    run(2);
    trigger = 0;
    push("zero_cfg_idle", 1, 0, 0, 0);
    run(1);

    // blank=2, window=0: acquisition skipped
    cfg_blank = 2; cfg_window = 0; trigger = 1;
    push("win0_blank", 1, 1, 0, 0); push("win0_blank", 1, 1, 0, 0);
    push("win0_done", 1, 0, 1, 0); push("win0_idle", 1, 0, 0, 0);
    run(4);
    trigger = 0;
    push("win0_idle", 1, 0, 0, 0);
    run(1);

    // retrigger and config change mid-acquisition are ignored
    cfg_blank = 1; cfg_window = 3; trigger = 1;
    push("retrig_blank", 1, 1, 0, 0);
    push("retrig_acq", 0, 1, 0, 0); push("retrig_acq", 0, 1, 0, 1); push("retrig_acq", 0, 1, 0, 2);
    push("retrig_done", 1, 0, 1, 3); push("retrig_idle", 1, 0, 0, 3); push("retrig_idle", 1, 0, 0, 3);
    run(1);
    trigger = 0;
    run(1);
    trigger = 1; cfg_blank = 0; cfg_window = 1;
    run(5);
    trigger = 0;
    push("retrig_idle", 1, 0, 0, 3);
    run(1);

    // reset during acquisition after one beat; trigger held through release
    cfg_blank = 0; cfg_window = 5; trigger = 1;
    push("rst_acq", 0, 1, 0, 0); push("rst_acq", 0, 1, 0, 1);
    run(2);
    areset = 1;
    push("rst_abort", 1, 0, 0, 0);
    run(1);
    areset = 0;
    repeat (3) push("rst_held_trig", 1, 0, 0, 0);
    run(3);
    trigger = 0;
    push("rst_idle", 1, 0, 0, 0);
    run(1);

    // tvalid high, tready low: stalls in acquisition, then completes
    cfg_blank = 0; cfg_window = 2; mon_tvalid = 1; mon_tready = 0; trigger = 1;
    repeat (6) push("stall_acq", 0, 1, 0, 0);
    run(6);
    mon_tready = 1;
    push("stall_acq", 0, 1, 0, 1); push("stall_done", 1, 0, 1, 2); push("stall_idle", 1, 0, 0, 2);
    run(3);

    checks++;
    assert (q.size() == 0) else begin
      errors++; $error("FAIL scoreboard_leftover obs=%0d exp=0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_zero_sequencer.md
AXIS_ZERO_SEQUENCER -- requirements
Module: axis_zero_sequencer

Interface
REQ-001 Parameter: AXIS_TDATA_WIDTH, default 32, width of the monitored stream (beat counting only; data not used).
REQ-002 Parameter: CNTR_WIDTH, default 32, width of all configuration values and counters.
REQ-003 aclk  input  1  sole clock; every register updates on its rising edge.
REQ-004 areset  input  1  reset; synchronous, active-high.
REQ-005 trigger  input  1  acquisition start request; rising edge significant.
REQ-006 cfg_blank  input  CNTR_WIDTH  blanking length in aclk cycles after trigger.
REQ-007 cfg_window  input  CNTR_WIDTH  acquisition length in accepted stream beats.
REQ-008 mon_tvalid  input  1  tvalid of the monitored stream (zeroer output side).
REQ-009 mon_tready  input  1  tready of the monitored stream.
REQ-010 zero  output  1  blanking control for the zeroer; 1 = data forced to zero.
REQ-011 busy  output  1  high in BLANK and ACQ.
REQ-012 done  output  1  one-cycle pulse at end of acquisition.
REQ-013 sts_count  output  CNTR_WIDTH  beats accepted in the current/last acquisition.

Function
REQ-014 States: IDLE, BLANK, ACQ, DONE; all outputs registered, no combinational input-to-output path.
REQ-015 Edge detect: trigger_edge = trigger & ~trigger_q, trigger_q a register of trigger.
REQ-016 IDLE: zero=1, busy=0; on trigger_edge latch cfg_blank/cfg_window, clear sts_count, clear cycle counter.
REQ-017 IDLE -> BLANK on trigger_edge when latched blank != 0; IDLE -> ACQ when blank == 0 and window != 0; IDLE -> DONE when both are 0; IDLE -> DONE when blank == 0 and window == 0 only.
REQ-018 BLANK: zero=1; cycle counter increments each cycle; after exactly blank cycles in BLANK, go to ACQ.
REQ-019 Latency: trigger_edge at cycle T -> zero deasserted from cycle T+blank+1 (blank=0: T+1).
REQ-020 ACQ: zero=0; beat = mon_tvalid & mon_tready; each beat increments sts_count.
REQ-021 ACQ -> DONE in the cycle sts_count reaches latched window; zero=1 from the cycle after the final beat.
REQ-022 Window==0 with blank!=0: BLANK -> DONE directly, ACQ skipped, zero never deasserted.
REQ-023 DONE: zero=1, busy=0, done=1 for exactly one cycle; next state IDLE.
REQ-024 trigger_edge outside IDLE ignored; configuration changes outside IDLE have no effect on the running sequence.
REQ-025 sts_count holds its final value in DONE and IDLE until the next accepted trigger_edge.
REQ-026 Counters wrap modulo 2^CNTR_WIDTH; no saturation logic; max window = 2^CNTR_WIDTH-1.

Reset
REQ-027 areset high at a clock edge -> state IDLE, zero=1, busy=0, done=0, sts_count=0, trigger_q=0, latched config=0.
REQ-028 Reset mid-BLANK or mid-ACQ aborts immediately; no done pulse emitted.
REQ-029 Trigger held high through reset release does not start a sequence; a new rising edge is required.

Verification
REQ-030 blank=4, window=3, mon_tvalid=mon_tready=1, edge at T -> zero=0 cycles T+5..T+7, done=1 at T+8, sts_count=3.
REQ-031 blank=2, window=2, beats only every 3rd cycle -> zero low until 2nd beat accepted, then done pulse, sts_count=2.
REQ-032 blank=0, window=0 -> zero stays 1, done at T+1, busy never high.
REQ-033 Second trigger edge during ACQ, cfg changed mid-run -> ignored, original window completed.
REQ-034 areset asserted in ACQ after 1 beat -> next cycle zero=1, busy=0, sts_count=0, no done.
REQ-035 mon_tvalid=1, mon_tready=0 throughout ACQ -> no beats counted, zero stays 0, busy stays 1.
